// File: rtl/rv_core_pkg.sv
// Shared core types: register index, data width and
// the writeback request bundle used by ALU, loads and FIFO.
package rv_core_pkg;

  localparam int XLEN     = 64;
  localparam int REGIDX_W = 5;

  localparam logic [REGIDX_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REGIDX_W-1:0] rd;
    logic [XLEN-1:0]     data;
  } wb_req_t;

endpackage

// File: rtl/regfile_writeback_arbiter_fifo.sv
// wb_sync_fifo: width/depth parameterised synchronous FIFO
// with async active-high reset and full/empty/count status.
module wb_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap on overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Register-file write port arbiter: ALU priority, buffered loads,
// anti-starvation alu_hold. Define WB_BYPASS_EN for fwd_* outputs.
module regfile_writeback_arbiter
  import rv_core_pkg::*;
#(
  parameter int LD_FIFO_DEPTH = 2,
  parameter int STARVE_MAX    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid,
  input  logic [REGIDX_W-1:0] alu_rd,
  input  logic [XLEN-1:0]     alu_data,
  output logic                alu_hold,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [REGIDX_W-1:0] ld_rd,
  input  logic [XLEN-1:0]     ld_data,
  output logic                RegWrite,
  output logic [REGIDX_W-1:0] rd,
  output logic [XLEN-1:0]     write_data
`ifdef WB_BYPASS_EN
  ,
  output logic                fwd_valid,
  output logic [REGIDX_W-1:0] fwd_rd,
  output logic [XLEN-1:0]     fwd_data
`endif
);

  localparam int CW = $clog2(LD_FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  wb_req_t       ld_req;
  wb_req_t       head;
  wb_req_t       sel;
  logic          sel_valid;
  logic          ld_win;
  logic          wb_en;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;
  logic [SW-1:0] starve_nxt;
  logic          hold_nxt;

  assign ld_req   = '{rd: ld_rd, data: ld_data};
  assign ld_ready = !full;

  wb_sync_fifo #(
    .WIDTH ($bits(wb_req_t)),
    .DEPTH (LD_FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ld_valid),
    .din   (ld_req),
    .pop   (ld_win),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    ld_win    = 1'b0;
    unique case (1'b1)
      alu_valid: begin
        sel       = '{rd: alu_rd, data: alu_data};
        sel_valid = 1'b1;
      end
      (!alu_valid && !empty): begin
        sel       = head;
        sel_valid = 1'b1;
        ld_win    = 1'b1;
      end
      (!alu_valid && empty): ;
    endcase
  end

  // x0 entries still win (and pop) but never write.
  assign wb_en = sel_valid && (sel.rd != REG_ZERO);

  always_comb begin
    starve_nxt = starve_cnt;
    hold_nxt   = 1'b0;
    if (count == '0 || ld_win) begin
      starve_nxt = '0;
    end else if (starve_cnt == SW'(STARVE_MAX - 1)) begin
      starve_nxt = '0;
      hold_nxt   = 1'b1;
    end else begin
      starve_nxt = starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWrite   <= 1'b0;
      rd         <= '0;
      write_data <= '0;
      alu_hold   <= 1'b0;
      starve_cnt <= '0;
    end else begin
      RegWrite   <= wb_en;
      rd         <= sel.rd;
      write_data <= sel.data;
      alu_hold   <= hold_nxt;
      starve_cnt <= starve_nxt;
    end
  end

`ifdef WB_BYPASS_EN
  assign fwd_valid = wb_en;
  assign fwd_rd    = sel.rd;
  assign fwd_data  = sel.data;
`endif

endmodule
